// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 emulator: validates the controller's Trigger pulse and answers with an
// Echo pulse whose width encodes a programmed (clamped) distance.
module hcsr04_echo_responder #(
  parameter int unsigned CYC_PER_US     = 50,
  parameter int unsigned TRIG_MIN_US    = 10,
  parameter int unsigned BURST_DELAY_US = 450,
  parameter int unsigned US_PER_CM      = 58,
  parameter int unsigned MIN_CM         = 2,
  parameter int unsigned MAX_CM         = 400,
  parameter int unsigned TIMEOUT_US     = 38000,
  parameter int unsigned HOLDOFF_US     = 10000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Trigger,
  input  logic [8:0] DistanciaCm,
  input  logic       Presente,
  output logic       Echo,
  output logic       Busy,
  output logic       Done,
  output logic       TrigError
);

  localparam int unsigned TMIN_CYC = TRIG_MIN_US * CYC_PER_US;
  localparam int unsigned DLY_CYC  = BURST_DELAY_US * CYC_PER_US;
  localparam int unsigned HOLD_CYC = HOLDOFF_US * CYC_PER_US;
  localparam int unsigned CM_CYC   = US_PER_CM * CYC_PER_US;
  localparam int unsigned TO_CYC   = TIMEOUT_US * CYC_PER_US;
  localparam int unsigned ECHO_MAX = (MAX_CM * CM_CYC > TO_CYC) ? MAX_CM * CM_CYC : TO_CYC;
  localparam int unsigned MAX_A    = (TMIN_CYC > DLY_CYC) ? TMIN_CYC : DLY_CYC;
  localparam int unsigned MAX_B    = (HOLD_CYC > ECHO_MAX) ? HOLD_CYC : ECHO_MAX;
  localparam int unsigned MAX_CNT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW       = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] TMIN_C = CW'(TMIN_CYC);
  localparam logic [CW-1:0] DLY_C  = CW'(DLY_CYC);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYC);
  localparam logic [CW-1:0] CM_C   = CW'(CM_CYC);
  localparam logic [CW-1:0] TO_C   = CW'(TO_CYC);
  localparam logic [8:0]    MIN_D  = 9'(MIN_CM);
  localparam logic [8:0]    MAX_D  = 9'(MAX_CM);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_DELAY, S_ECHO, S_HOLD} state_t;

  state_t        state, nextState;
  logic          trigMeta, trigS, trigPrev;
  logic [CW-1:0] cnt, echoLen, echoCalc, dExt;
  logic [8:0]    dClamp;
  logic          echoNxt, busyNxt, doneNxt, trigErrNxt;

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_IDLE;
    else        state <= nextState;
  end

  // Next-state logic; IDLE starts only on a fresh rising edge of trigS
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (trigS && !trigPrev) nextState = S_TRIG;
      S_TRIG:  if (!trigS) nextState = (cnt >= TMIN_C) ? S_DELAY : S_IDLE;
      S_DELAY: if (cnt == DLY_C - CW'(1)) nextState = S_ECHO;
      S_ECHO:  if (cnt == echoLen) nextState = S_HOLD;
      S_HOLD:  if (cnt == HOLD_C) nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Output decode, registered below so outputs line up with the new state
  always_comb begin
    echoNxt    = 1'b0;
    busyNxt    = 1'b0;
    doneNxt    = 1'b0;
    trigErrNxt = 1'b0;
    echoNxt    = (nextState == S_ECHO);
    busyNxt    = (nextState != S_IDLE);
    doneNxt    = (state == S_ECHO) && (nextState == S_HOLD);
    trigErrNxt = (state == S_TRIG) && (nextState == S_IDLE);
  end

  // Echo length for the distance presented at the Trigger fall
  always_comb begin
    dClamp = DistanciaCm;
    if (DistanciaCm < MIN_D)      dClamp = MIN_D;
    else if (DistanciaCm > MAX_D) dClamp = MAX_D;
    dExt     = CW'(dClamp);
    echoCalc = Presente ? dExt * CM_C : TO_C;
  end

  // Synchronizer, phase counter, latched echo length and output registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      trigMeta  <= 1'b0;
      trigS     <= 1'b0;
      trigPrev  <= 1'b0;
      cnt       <= '0;
      echoLen   <= '0;
      Echo      <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      TrigError <= 1'b0;
    end else begin
      trigMeta  <= Trigger;
      trigS     <= trigMeta;
      trigPrev  <= trigS;
      Echo      <= echoNxt;
      Busy      <= busyNxt;
      Done      <= doneNxt;
      TrigError <= trigErrNxt;
      if (state != nextState)
        cnt <= (nextState == S_IDLE) ? '0 : CW'(1);
      else if (state == S_TRIG) begin
        if (trigS && (cnt < TMIN_C)) cnt <= cnt + CW'(1);
      end else if (state != S_IDLE)
        cnt <= cnt + CW'(1);
      if ((state == S_TRIG) && (nextState == S_DELAY)) echoLen <= echoCalc;
    end
  end

endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// Bench for hcsr04_echo_responder with scaled-down timing parameters; expected
// Echo/Done/Busy/TrigError timing is derived arithmetically from the Trigger fall.
module tb_hcsr04_echo_responder;

  localparam int CYC = 1, TMIN_US = 10, DLY_US = 45, UPC = 3;
  localparam int MINC = 2, MAXC = 400, TO_US = 1500, HOLD_US = 100;
  localparam int DLY = DLY_US * CYC, HOLD = HOLD_US * CYC, TMIN = TMIN_US * CYC;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Trigger = 1'b0;
  logic [8:0] DistanciaCm = 9'd0;
  logic       Presente = 1'b1;
  logic       Echo, Busy, Done, TrigError;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int riseCnt = 0, riseCyc = 0, fallCyc = 0, doneCnt = 0, doneCyc = 0;
  int terrCnt = 0, terrCyc = 0, busyFallCnt = 0, busyFallCyc = 0;
  logic prevEcho = 1'b0, prevBusy = 1'b0;

  hcsr04_echo_responder #(
    .CYC_PER_US(CYC), .TRIG_MIN_US(TMIN_US), .BURST_DELAY_US(DLY_US),
    .US_PER_CM(UPC), .MIN_CM(MINC), .MAX_CM(MAXC),
    .TIMEOUT_US(TO_US), .HOLDOFF_US(HOLD_US)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Trigger(Trigger), .DistanciaCm(DistanciaCm),
    .Presente(Presente), .Echo(Echo), .Busy(Busy), .Done(Done), .TrigError(TrigError)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Event monitor sampled mid-cycle
  always @(negedge Clock) begin
    if (Echo && !prevEcho) begin riseCnt <= riseCnt + 1; riseCyc <= cyc; end
    if (!Echo && prevEcho) fallCyc <= cyc;
    if (Done) begin doneCnt <= doneCnt + 1; doneCyc <= cyc; end
    if (TrigError) begin terrCnt <= terrCnt + 1; terrCyc <= cyc; end
    if (!Busy && prevBusy) begin busyFallCnt <= busyFallCnt + 1; busyFallCyc <= cyc; end
    prevEcho <= Echo;
    prevBusy <= Busy;
  end

  function automatic int echoLen(input int d, input bit p);
    int c;
    c = (d < MINC) ? MINC : (d > MAXC) ? MAXC : d;
    return p ? c * UPC * CYC : TO_US * CYC;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One trigger of width hi cycles, then wait for Busy to drop and check timing
  task automatic measure(input string tag, input int hi, input int d, input bit p,
                         input bit retrig, input bit chgDist);
    int m, f, e, bRise, bDone, bTerr, bBusy, timedOut;
    bit valid;
    DistanciaCm = 9'(d);
    Presente    = p;
    @(posedge Clock); #1;
    bRise = riseCnt; bDone = doneCnt; bTerr = terrCnt; bBusy = busyFallCnt;
    Trigger = 1'b1;
    repeat (hi) begin @(posedge Clock); #1; end
    m = cyc;
    Trigger = 1'b0;
    f = m + 2;
    valid = (hi >= TMIN);
    e = echoLen(d, p);
    timedOut = 1;
    for (int t = 0; t < 4000; t++) begin
      @(posedge Clock); #1;
      if (chgDist && cyc == f + 1) DistanciaCm = 9'd50;
      if (retrig) begin
        if (cyc == f + DLY + 5)       Trigger = 1'b1;
        if (cyc == f + DLY + 25)      Trigger = 1'b0;
        if (cyc == f + DLY + e + 10)  Trigger = 1'b1;
        if (cyc == f + DLY + e + 30)  Trigger = 1'b0;
      end
      if (busyFallCnt != bBusy) begin timedOut = 0; break; end
    end
    repeat (5) @(posedge Clock);
    #1;
    chk({tag, "_timeout"}, timedOut, 0);
    if (valid) begin
      chk({tag, "_rise_cnt"}, riseCnt - bRise, 1);
      chk({tag, "_rise_cyc"}, riseCyc, f + DLY);
      chk({tag, "_fall_cyc"}, fallCyc, f + DLY + e);
      chk({tag, "_done_cnt"}, doneCnt - bDone, 1);
      chk({tag, "_done_cyc"}, doneCyc, f + DLY + e);
      chk({tag, "_busy_fall"}, busyFallCyc, f + DLY + e + HOLD);
      chk({tag, "_terr_cnt"}, terrCnt - bTerr, 0);
    end else begin
      chk({tag, "_terr_cnt"}, terrCnt - bTerr, 1);
      chk({tag, "_terr_cyc"}, terrCyc, f + 1);
      chk({tag, "_busy_fall"}, busyFallCyc, f + 1);
      chk({tag, "_rise_cnt"}, riseCnt - bRise, 0);
      chk({tag, "_done_cnt"}, doneCnt - bDone, 0);
    end
  endtask

  initial begin
    int m, f;
    // Reset state
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_echo", int'(Echo), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_terr", int'(TrigError), 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);

    measure("nominal", 12, 100, 1'b1, 1'b0, 1'b0);
    measure("short5", 5, 100, 1'b1, 1'b0, 1'b0);
    measure("tmin_exact", TMIN, 37, 1'b1, 1'b0, 1'b0);
    measure("tmin_minus1", TMIN - 1, 37, 1'b1, 1'b0, 1'b0);
    measure("absent", 12, 100, 1'b0, 1'b0, 1'b0);
    measure("clamp_hi", 12, 511, 1'b1, 1'b0, 1'b0);
    measure("clamp_lo0", 12, 0, 1'b1, 1'b0, 1'b0);
    measure("clamp_lo1", 12, 1, 1'b1, 1'b0, 1'b0);
    measure("retrig", 12, 100, 1'b1, 1'b1, 1'b0);
    measure("after_retrig", 15, 200, 1'b1, 1'b0, 1'b0);
    measure("dist_change", 12, 100, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of ECHO
    DistanciaCm = 9'd100;
    Presente = 1'b1;
    @(posedge Clock); #1;
    Trigger = 1'b1;
    repeat (12) begin @(posedge Clock); #1; end
    m = cyc;
    Trigger = 1'b0;
    f = m + 2;
    while (cyc < f + DLY + 150) begin @(posedge Clock); #1; end
    chk("echo_before_rst", int'(Echo), 1);
    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("midrst_echo", int'(Echo), 0);
    chk("midrst_busy", int'(Busy), 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    measure("post_rst", 12, 100, 1'b1, 1'b0, 1'b0);

    // Randomized measurements
    for (int i = 0; i < 8; i++) begin
      int hi, d;
      bit p;
      hi = int'($urandom_range(4, 20));
      d  = int'($urandom_range(0, 511));
      p  = ($urandom_range(0, 3) != 0);
      measure($sformatf("rand%0d", i), hi, d, p, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hcsr04_echo_responder.md
Name: hcsr04_echo_responder

Overview:
- Sensor-side responder for the ultrasonic trigger/echo protocol, i.e. an HC-SR04 emulator.
- Accepts the Trigger pulse produced by the measurement controller and validates its width.
- After a fixed acoustic-burst delay, drives Echo high for a time proportional to a programmed distance.
- Used for hardware-in-loop self-test and as the bench responder for the distance-measurement path.

Parameters:
- CYC_PER_US, 50, clock cycles per microsecond (50 MHz).
- TRIG_MIN_US, 10, minimum valid Trigger high width in µs.
- BURST_DELAY_US, 450, delay from Trigger fall to Echo rise in µs.
- US_PER_CM, 58, Echo width per cm, round trip.
- MIN_CM, 2, lower clamp on distance.
- MAX_CM, 400, upper clamp on distance.
- TIMEOUT_US, 38000, Echo width when no object is present.
- HOLDOFF_US, 10000, dead time after Echo falls in µs.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-low (Reset=0 resets).
- Trigger  in  1  asynchronous trigger from controller.
- DistanciaCm  in  9  emulated target distance in cm.
- Presente  in  1  1 = object present; 0 = no echo (timeout width).
- Echo  out  1  echo pulse to controller.
- Busy  out  1  high while a measurement cycle is in progress.
- Done  out  1  one-cycle pulse when Echo falls.
- TrigError  out  1  one-cycle pulse when a too-short Trigger is rejected.

Behaviour:
- Reset (Reset=0 at a Clock edge): Echo=0, Busy=0, Done=0, TrigError=0, state=IDLE, all counters=0, synchronizer flops=0. Reset mid-operation aborts at once; Echo is low after that edge.
- Trigger passes through a 2-flop synchronizer; trig_s is the stage-2 output. All timing below is referenced to trig_s.
- Derived cycle counts:
  - TMIN = TRIG_MIN_US*CYC_PER_US
  - DLY = BURST_DELAY_US*CYC_PER_US
  - HOLD = HOLDOFF_US*CYC_PER_US
  - ECHO = d*US_PER_CM*CYC_PER_US, where d = clamp(DistanciaCm, MIN_CM, MAX_CM) if Presente=1, else ECHO = TIMEOUT_US*CYC_PER_US.
- Counter width: enough for the largest count (TIMEOUT: 1.9e6 cycles → 21 bits); compute width from parameters. No overflow is permitted.
- States:
  - IDLE: Busy=0. On trig_s=1, go to TRIG and set width counter = 1.
  - TRIG: Busy=1; width counter increments while trig_s=1, saturating at TMIN. On trig_s=0 (cycle F):
    - if count ≥ TMIN: latch DistanciaCm/Presente, compute ECHO, go to DELAY.
    - else: pulse TrigError for 1 cycle, go to IDLE.
  - DELAY: Busy=1. Echo rises exactly DLY cycles after F (Echo=1 from cycle F+DLY). Go to ECHO.
  - ECHO: Echo=1 for exactly ECHO cycles. In the cycle Echo returns to 0, Done=1 for one cycle. Go to HOLD.
  - HOLD: Busy=1, Echo=0 for HOLD cycles, then go to IDLE. IDLE accepts a new pulse only after it sees trig_s=0 followed by trig_s=1; a Trigger already high on entering IDLE is ignored until it falls.
- Trigger edges in DELAY, ECHO or HOLD are ignored entirely.
- Trigger held high indefinitely: remain in TRIG; no Echo is produced.
- DistanciaCm and Presente are sampled only at cycle F; later changes do not affect the current Echo.
- DistanciaCm=0 or 1 clamps to MIN_CM; values >400 clamp to MAX_CM.

Test Plan:
- Defaults, DistanciaCm=100, Presente=1, Trigger high 12 µs (600 cycles) → Echo rises 22500 cycles after F; high for 290000 cycles; Done pulses once at the fall.
- Trigger high 5 µs (250 cycles) → TrigError one-cycle pulse, Echo stays 0, Busy returns to 0 the next cycle.
- Presente=0, valid trigger → Echo high for 1900000 cycles. DistanciaCm=511 → 1160000 cycles (clamped to 400). DistanciaCm=0 → 5800 cycles (clamped to 2).
- Second Trigger pulse issued during ECHO, and again during HOLD → ignored: no change to Echo width, no extra Done. A trigger after HOLD ends is serviced normally.
- Reset=0 asserted midway through ECHO → Echo=0, Busy=0 after that edge. After release, a new valid trigger produces a correct full cycle.
- DistanciaCm changed from 100 to 50 one cycle after F → Echo width still 290000 cycles.
